// File: rtl/window_sequencer.sv
// rtl/window_sequencer.sv - KxK sliding window sequencer over a square pixel memory
// Build option: define WINSEQ_SLIDE_EN to reuse the overlapping K-1 columns
//   when Y advances (K reads per window). Without it every window is refetched
//   in full (K*K reads per window).
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   START              frame request, sampled only in IDLE
//   RADDR, RDATA       pixel memory read port, RDATA valid one cycle after RADDR
//   IMGIN              window, pixel (i,j) at bits [(i*K+j)*PIX_W +: PIX_W]
//   X, Y               window top row, left column
//   WIN_VALID          IMGIN/X/Y hold a complete window
//   WIN_READY          consumer accepts the window
//   BUSY               high whenever not IDLE
//   FRAME_DONE         one-cycle pulse after the last window is accepted
module window_sequencer #(
    parameter int IMG_W = 28,
    parameter int K     = 5,
    parameter int PIX_W = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 START,
    output logic [9:0]           RADDR,
    input  logic [PIX_W-1:0]     RDATA,
    output logic [K*K*PIX_W-1:0] IMGIN,
    output logic [4:0]           X,
    output logic [4:0]           Y,
    output logic                 WIN_VALID,
    input  logic                 WIN_READY,
    output logic                 BUSY,
    output logic                 FRAME_DONE
);

    localparam int N  = IMG_W - K + 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [4:0]    LAST = 5'(N - 1);
    localparam logic [CW-1:0] KM1  = CW'(K - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_EMIT  = 3'd2,
`ifdef WINSEQ_SLIDE_EN
        S_SHIFT = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t        state;
    logic          issuing;          // read generator active
    logic [CW-1:0] ri, cj;           // row/column of the next read within the window
    logic          p1_v, p2_v;       // read in flight: address on RADDR / data on RDATA
    logic [CW-1:0] p1_ri, p1_cj, p2_ri, p2_cj;
    logic [9:0]    rd_addr;
    int            slot_lsb;
    logic          last_issue;
    logic          last_cap;

    always_comb begin
        rd_addr    = 10'((int'(X) + int'(ri)) * IMG_W + int'(Y) + int'(cj));
        slot_lsb   = (int'(p2_ri) * K + int'(p2_cj)) * PIX_W;
        // Both FILL and SHIFT finish on slot (K-1,K-1).
        last_issue = (ri == KM1) && (cj == KM1);
        last_cap   = p2_v && (p2_ri == KM1) && (p2_cj == KM1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= S_IDLE;
            issuing    <= 1'b0;
            ri         <= '0;
            cj         <= '0;
            p1_v       <= 1'b0;
            p1_ri      <= '0;
            p1_cj      <= '0;
            p2_v       <= 1'b0;
            p2_ri      <= '0;
            p2_cj      <= '0;
            RADDR      <= '0;
            IMGIN      <= '0;
            X          <= '0;
            Y          <= '0;
            WIN_VALID  <= 1'b0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            // Two-stage read tag pipeline tracks which slot RDATA belongs to.
            RADDR <= '0;
            p1_v  <= 1'b0;
            p2_v  <= p1_v;
            p2_ri <= p1_ri;
            p2_cj <= p1_cj;

            if (issuing) begin
                RADDR <= rd_addr;
                p1_v  <= 1'b1;
                p1_ri <= ri;
                p1_cj <= cj;
                if (last_issue) begin
                    issuing <= 1'b0;
                end else if (state == S_FILL) begin
                    if (cj == KM1) begin
                        cj <= '0;
                        ri <= ri + CW'(1);
                    end else begin
                        cj <= cj + CW'(1);
                    end
                end
`ifdef WINSEQ_SLIDE_EN
                else begin
                    ri <= ri + CW'(1);
                end
`endif
            end

            if (p2_v) begin
                IMGIN[slot_lsb +: PIX_W] <= RDATA;
            end

            case (state)
                S_IDLE: begin
                    if (START) begin
                        state   <= S_FILL;
                        X       <= '0;
                        Y       <= '0;
                        BUSY    <= 1'b1;
                        issuing <= 1'b1;
                        ri      <= '0;
                        cj      <= '0;
                    end
                end
`ifdef WINSEQ_SLIDE_EN
                S_SHIFT,
`endif
                S_FILL: begin
                    if (last_cap) begin
                        WIN_VALID <= 1'b1;
                        state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (WIN_READY) begin
                        WIN_VALID <= 1'b0;
                        if (Y != LAST) begin
                            Y       <= Y + 5'd1;
                            issuing <= 1'b1;
                            ri      <= '0;
`ifdef WINSEQ_SLIDE_EN
                            // Slide left by one column; only column K-1 is refetched.
                            state <= S_SHIFT;
                            cj    <= KM1;
                            for (int i = 0; i < K; i++) begin
                                for (int j = 0; j < K - 1; j++) begin
                                    IMGIN[(i*K+j)*PIX_W +: PIX_W] <= IMGIN[(i*K+j+1)*PIX_W +: PIX_W];
                                end
                            end
`else
                            state <= S_FILL;
                            cj    <= '0;
`endif
                        end else if (X != LAST) begin
                            Y       <= '0;
                            X       <= X + 5'd1;
                            state   <= S_FILL;
                            issuing <= 1'b1;
                            ri      <= '0;
                            cj      <= '0;
                        end else begin
                            state      <= S_DONE;
                            FRAME_DONE <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    FRAME_DONE <= 1'b0;
                    BUSY       <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_sequencer.sv
// tb/tb_window_sequencer.sv - scoreboard bench for window_sequencer
module tb_window_sequencer;

    localparam int IMG_W = 28;
    localparam int K     = 5;
    localparam int PIX_W = 8;
    localparam int N     = IMG_W - K + 1;
    localparam int WB    = K * K * PIX_W;
`ifdef WINSEQ_SLIDE_EN
    localparam bit SLIDE = 1'b1;
`else
    localparam bit SLIDE = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             nRST;
    logic             START;
    logic [9:0]       RADDR;
    logic [PIX_W-1:0] RDATA = '0;
    logic [WB-1:0]    IMGIN;
    logic [4:0]       X, Y;
    logic             WIN_VALID;
    logic             WIN_READY = 1'b0;
    logic             BUSY;
    logic             FRAME_DONE;

    window_sequencer #(.IMG_W(IMG_W), .K(K), .PIX_W(PIX_W)) dut (
        .CLK(CLK), .nRST(nRST), .START(START), .RADDR(RADDR), .RDATA(RDATA),
        .IMGIN(IMGIN), .X(X), .Y(Y), .WIN_VALID(WIN_VALID), .WIN_READY(WIN_READY),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    logic [PIX_W-1:0] mem [IMG_W*IMG_W];
    always @(posedge CLK) RDATA <= mem[RADDR];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // Reference model: a window is just the KxK block of the image at (x,y).
    typedef struct {
        int            x;
        int            y;
        logic [WB-1:0] img;
    } win_t;

    win_t exp_q[$];
    int   addr_q[$];

    task automatic push_frame();
        win_t w;
        for (int x = 0; x < N; x++) begin
            for (int y = 0; y < N; y++) begin
                w.x = x;
                w.y = y;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        w.img[(i*K+j)*PIX_W +: PIX_W] = mem[(x+i)*IMG_W + y + j];
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic push_reads(input int x, input int y, input bit col_only);
        for (int i = 0; i < K; i++) begin
            if (col_only) addr_q.push_back((x+i)*IMG_W + y + K - 1);
            else for (int j = 0; j < K; j++) addr_q.push_back((x+i)*IMG_W + y + j);
        end
    endtask

    // Monitor: negedge sampling; cyc equals the index of the rising edge just passed.
    int            cyc = 0;
    bit            model_idle = 1'b1;
    int            idle_at = -1, fd_at = -1;
    int            entry = 0, rd_first = 0, exp_lat = 0;
    bit            awaiting = 1'b0, stalled = 1'b0, prev_valid = 1'b0;
    logic [4:0]    hx, hy;
    logic [WB-1:0] himg;
    int            frames_done = 0;
    int            last_x = -1, last_y = -1;

    always @(negedge CLK) begin
        win_t w;
        int   a, nx, ny;
        bit   col_only;
        cyc++;
        if (!nRST) begin
            exp_q.delete();
            addr_q.delete();
            model_idle = 1'b1;
            idle_at = -1;
            fd_at = -1;
            awaiting = 1'b0;
            stalled = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (cyc == idle_at) model_idle = 1'b1;
            chk("busy", WB'(BUSY), WB'(!model_idle));
            chk("frame_done", WB'(FRAME_DONE), WB'(cyc == fd_at));
            if (FRAME_DONE) frames_done++;

            if (addr_q.size() > 0 && cyc >= rd_first) begin
                a = addr_q.pop_front();
                chk("raddr", WB'(RADDR), WB'(a));
            end else begin
                chk("raddr_idle", WB'(RADDR), WB'(0));
            end

            if (awaiting) begin
                if (WIN_VALID) begin
                    chk("win_latency", WB'(cyc - entry), WB'(exp_lat));
                    awaiting = 1'b0;
                end else if (cyc - entry >= exp_lat) begin
                    fail("win_late");
                    awaiting = 1'b0;
                end
            end else if (WIN_VALID && !prev_valid) begin
                fail("win_spurious");
            end

            if (stalled) begin
                chk("stall_valid", WB'(WIN_VALID), WB'(1));
                chk("stall_x", WB'(X), WB'(hx));
                chk("stall_y", WB'(Y), WB'(hy));
                chk("stall_img", IMGIN, himg);
            end
            stalled = WIN_VALID && !WIN_READY;
            hx = X;
            hy = Y;
            himg = IMGIN;
            prev_valid = WIN_VALID;

            if (WIN_VALID && WIN_READY) begin
                if (exp_q.size() == 0) begin
                    fail("win_unexpected");
                end else begin
                    w = exp_q.pop_front();
                    chk("win_x", WB'(X), WB'(w.x));
                    chk("win_y", WB'(Y), WB'(w.y));
                    chk("win_img", IMGIN, w.img);
                    last_x = w.x;
                    last_y = w.y;
                    if (w.x == N-1 && w.y == N-1) begin
                        fd_at = cyc + 1;
                        idle_at = cyc + 2;
                    end else begin
                        nx = (w.y == N-1) ? w.x + 1 : w.x;
                        ny = (w.y == N-1) ? 0 : w.y + 1;
                        col_only = SLIDE && (ny != 0);
                        entry = cyc + 1;
                        rd_first = cyc + 2;
                        exp_lat = col_only ? K + 2 : K*K + 2;
                        awaiting = 1'b1;
                        push_reads(nx, ny, col_only);
                    end
                end
            end

            if (model_idle && START) begin
                model_idle = 1'b0;
                push_frame();
                entry = cyc + 1;
                rd_first = cyc + 2;
                exp_lat = K*K + 2;
                awaiting = 1'b1;
                push_reads(0, 0, 1'b0);
            end
        end
    end

    bit ready_rand = 1'b0;
    always @(posedge CLK) begin
        #1;
        WIN_READY = ready_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    task automatic wait_frames(input int target, input string name);
        int t;
        t = 0;
        while (frames_done < target && t < 40000) begin
            @(posedge CLK);
            t++;
        end
        chk(name, WB'(frames_done), WB'(target));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_raddr"}, WB'(RADDR), WB'(0));
        chk({tag, "_imgin"}, IMGIN, WB'(0));
        chk({tag, "_x"}, WB'(X), WB'(0));
        chk({tag, "_y"}, WB'(Y), WB'(0));
        chk({tag, "_valid"}, WB'(WIN_VALID), WB'(0));
        chk({tag, "_busy"}, WB'(BUSY), WB'(0));
        chk({tag, "_done"}, WB'(FRAME_DONE), WB'(0));
    endtask

    initial begin
        int t;
        nRST = 1'b1;
        START = 1'b0;
        for (int a = 0; a < IMG_W*IMG_W; a++) mem[a] = PIX_W'(a);

        #2 nRST = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;

        // Frame A: ramp image, consumer always ready, stray START pulses while busy.
        repeat (2) @(posedge CLK);
        #1 START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (2000) begin
            @(posedge CLK);
            #1 START = ($urandom_range(0, 9) == 0);
        end
        START = 1'b0;
        wait_frames(1, "frame_a_done");

        // Frame B: random image, 30% ready, START held high so frame C follows.
        repeat (3) @(posedge CLK);
        for (int a = 0; a < IMG_W*IMG_W; a++) mem[a] = PIX_W'($urandom);
        #1 ready_rand = 1'b1;
        START = 1'b1;
        wait_frames(2, "frame_b_done");
        repeat (4) @(posedge CLK);
        #1 START = 1'b0;
        ready_rand = 1'b0;
        chk("frame_c_busy", WB'(BUSY), WB'(1));

        // Abort frame C while window (10,7) is being built.
        t = 0;
        while (!(last_x == 10 && last_y == 6) && t < 20000) begin
            @(posedge CLK);
            t++;
        end
        chk("reach_10_6", WB'((last_x == 10) && (last_y == 6)), WB'(1));
        repeat (3) @(posedge CLK);
        #3 nRST = 1'b0;
        #1 chk_reset_outputs("abort");
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Frame D: ramp image restarted from (0,0).
        for (int a = 0; a < IMG_W*IMG_W; a++) mem[a] = PIX_W'(a);
        repeat (2) @(posedge CLK);
        #1 START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        wait_frames(3, "frame_d_done");
        repeat (5) @(posedge CLK);
        chk("windows_left", WB'(exp_q.size()), WB'(0));
        chk("final_busy", WB'(BUSY), WB'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge CLK);
        fail("watchdog");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
